// File: rtl/stat_tx_pkg.sv
// Shared types and sizes for the serial status reporter and its UART helpers.
package stat_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;
  localparam int STAT_W     = 6;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: one-cycle tick on the last clock of every UART bit.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic in_clk,
  input  logic in_rst_n,
  input  logic in_clr,
  output logic out_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Held at zero while cleared, so the first bit after a clear is full length.
  assign out_tick = !in_clr && (r_cnt == TERM);

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_cnt <= '0;
    end else if (in_clr || out_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/stat_tx.sv
// Sends {2'b00, status} as one 8N1 UART frame on request or on status change.
module stat_tx
  import stat_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter bit AUTO_SEND    = 1'b1
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic [STAT_W-1:0] in_stat,
  input  logic              in_req,
  output logic              out_tx,
  output logic              out_busy,
  output logic              out_done
);

  tx_state_t             r_state;
  logic [DATA_BITS-1:0]  r_shift;
  logic [2:0]            r_bit;
  logic                  r_pending;
  logic [STAT_W-1:0]     r_last;
  logic                  r_tx;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_clr;
  logic                  w_tick;
  logic                  w_auto;
  logic                  w_launch;
  logic [DATA_BITS-1:0]  w_shift_nxt;

  assign w_clr       = (r_state == IDLE);
  assign w_auto      = AUTO_SEND && (in_stat != r_last);
  assign w_launch    = (r_state == IDLE) && (in_req || w_auto || r_pending);
  assign w_shift_nxt = r_shift >> 1;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .in_clk   (in_clk),
    .in_rst_n (in_rst_n),
    .in_clr   (w_clr),
    .out_tick (w_tick)
  );

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit     <= '0;
      r_pending <= 1'b0;
      r_last    <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Only explicit requests queue while busy; a status change is re-evaluated
      // in IDLE against last_sent, so a change that reverts mid-frame sends nothing.
      if (r_state != IDLE && in_req) begin
        r_pending <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_launch) begin
            r_shift   <= {{(DATA_BITS-STAT_W){1'b0}}, in_stat};
            r_last    <= in_stat;
            r_pending <= 1'b0;
            r_bit     <= '0;
            r_state   <= START;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        START: begin
          if (w_tick) begin
            r_state <= DATA;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_bit == 3'(DATA_BITS - 1)) begin
              r_state <= STOP;
              r_tx    <= 1'b1;
            end else begin
              r_shift <= w_shift_nxt;
              r_tx    <= w_shift_nxt[0];
              r_bit   <= r_bit + 3'd1;
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_tx   = r_tx;
  assign out_busy = r_busy;
  assign out_done = r_done;

endmodule

// File: tb/tb_stat_tx.sv
// Scoreboard bench for stat_tx: three instances (CPB=4 manual, CPB=4 auto, CPB=2 manual).
module tb_stat_tx;
  import stat_tx_pkg::*;

  typedef struct {
    logic [7:0] data;
    int         start;
  } exp_t;

  logic       clk;
  logic [2:0] rst_n;
  logic [2:0] req;
  logic [2:0] tx;
  logic [2:0] busy;
  logic [2:0] done;
  logic [5:0] stat [3];

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t q [3][$];
  bit   mon_en [3];
  bit   mon_busy [3];
  int   unexp [3];
  int   sp_done [3];

  stat_tx #(.CLKS_PER_BIT(4), .AUTO_SEND(1'b0)) u_man (
    .in_clk(clk), .in_rst_n(rst_n[0]), .in_stat(stat[0]), .in_req(req[0]),
    .out_tx(tx[0]), .out_busy(busy[0]), .out_done(done[0]));

  stat_tx #(.CLKS_PER_BIT(4), .AUTO_SEND(1'b1)) u_auto (
    .in_clk(clk), .in_rst_n(rst_n[1]), .in_stat(stat[1]), .in_req(req[1]),
    .out_tx(tx[1]), .out_busy(busy[1]), .out_done(done[1]));

  stat_tx #(.CLKS_PER_BIT(2), .AUTO_SEND(1'b0)) u_fast (
    .in_clk(clk), .in_rst_n(rst_n[2]), .in_stat(stat[2]), .in_req(req[2]),
    .out_tx(tx[2]), .out_busy(busy[2]), .out_done(done[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h, required %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_frame(input int id, input logic [7:0] d, input int s);
    exp_t e;
    e.data  = d;
    e.start = s;
    q[id].push_back(e);
  endtask

  // Line monitor: on a start bit, pop the expected frame and check every cycle.
  task automatic mon(input int id);
    int         c;
    exp_t       e;
    logic [9:0] fr;
    c = (id == 2) ? 2 : 4;
    forever begin
      @(negedge clk);
      if (mon_en[id] && rst_n[id]) begin
        if (done[id]) sp_done[id]++;
        if (tx[id] == 1'b0) begin
          mon_busy[id] = 1'b1;
          if (q[id].size() != 0) begin
            e = q[id].pop_front();
            if (e.start >= 0) chk($sformatf("start%0d", id), cyc, e.start);
            fr = {1'b1, e.data, 1'b0};
            for (int i = 0; i < 10 * c; i++) begin
              if (i > 0) @(negedge clk);
              chk($sformatf("line%0d_bit%0d", id, i / c),
                  32'({done[id], busy[id], tx[id]}), 32'({1'b0, 1'b1, fr[i / c]}));
            end
            @(negedge clk);
            chk($sformatf("done%0d", id), 32'({done[id], busy[id], tx[id]}), 32'h5);
          end else begin
            unexp[id]++;
            repeat (10 * c) @(negedge clk);
          end
          mon_busy[id] = 1'b0;
        end
      end
    end
  endtask

  task automatic drain(input int id, input int budget);
    int n;
    n = 0;
    while ((q[id].size() != 0 || mon_busy[id]) && n < budget) begin
      step(1);
      n++;
    end
    chk($sformatf("drain%0d", id), q[id].size() + int'(mon_busy[id]), 0);
  endtask

  initial begin
    fork
      mon(0);
      mon(1);
      mon(2);
    join_none
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    int n;
    rst_n = 3'b000;
    req   = 3'b000;
    for (int i = 0; i < 3; i++) begin
      stat[i]   = 6'h00;
      mon_en[i] = 1'b1;
    end

    @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("reset%0d", i), 32'({tx[i], busy[i], done[i]}), 32'h4);
    step(2);
    rst_n = 3'b111;

    // Idle after reset with zero status
    step(100);
    chk("idle_man", 32'({tx[0], busy[0]}), 32'h2);
    chk("idle_auto", 32'({tx[1], busy[1]}), 32'h2);
    chk("idle_man_no_done", sp_done[0], 0);

    // Single request 0x2D, then a merged pending request carrying 0x15
    step(1);
    t = cyc;
    stat[0] = 6'h2D;
    req[0]  = 1'b1;
    expect_frame(0, 8'h2D, t + 1);
    step(1);
    req[0] = 1'b0;
    step(9);
    req[0] = 1'b1;
    step(1);
    req[0] = 1'b0;
    step(9);
    stat[0] = 6'h15;
    expect_frame(0, 8'h15, t + 42);
    drain(0, 200);

    // Auto-send: 0 -> 0x3F, then 0x01 mid-frame
    step(1);
    t = cyc;
    stat[1] = 6'h3F;
    expect_frame(1, 8'h3F, t + 1);
    step(15);
    stat[1] = 6'h01;
    expect_frame(1, 8'h01, t + 42);
    drain(1, 200);
    step(100);
    chk("auto_no_extra_frames", unexp[1], 0);
    chk("auto_no_extra_done", sp_done[1], 0);

    // Reset in the middle of bit 3 (a zero bit of 0x2A)
    mon_en[0] = 1'b0;
    step(1);
    t = cyc;
    stat[0] = 6'h2A;
    req[0]  = 1'b1;
    step(1);
    req[0] = 1'b0;
    step(13);
    chk("pre_reset_line", 32'({tx[0], busy[0]}), 32'h1);
    #2 rst_n[0] = 1'b0;
    #1 chk("async_reset", 32'({tx[0], busy[0], done[0]}), 32'h4);
    step(2);
    rst_n[0] = 1'b1;
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0) n++;
    end
    chk("post_reset_quiet", n, 0);
    step(1);
    mon_en[0] = 1'b1;

    // CPB=2: request on the done cycle, then on the final stop cycle
    step(1);
    t = cyc;
    stat[2] = 6'h12;
    req[2]  = 1'b1;
    expect_frame(2, 8'h12, t + 1);
    step(1);
    req[2] = 1'b0;
    step(20);
    req[2]  = 1'b1;
    stat[2] = 6'h33;
    expect_frame(2, 8'h33, t + 22);
    step(1);
    req[2] = 1'b0;
    step(19);
    req[2] = 1'b1;
    expect_frame(2, 8'h33, t + 43);
    step(1);
    req[2] = 1'b0;
    drain(2, 200);
    step(20);

    for (int i = 0; i < 3; i++) begin
      chk($sformatf("no_unexpected_frame%0d", i), unexp[i], 0);
      chk($sformatf("no_spurious_done%0d", i), sp_done[i], 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stat_tx.md
# stat_tx

Serial status reporter: returns the tester's 6-bit status word to the host over the UART TX line, so the host can read back what it wrote. Sends one 8N1 frame carrying `{2'b00, status}` on an explicit request or, when enabled, whenever the status changes. Sits beside the status register and drives the board's UART TX pin directly.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per UART bit (50 MHz / 115200); must be ≥ 2.
- `AUTO_SEND`, 1, 1 = also transmit automatically when `in_stat` differs from the last value sent.
- `in_clk`  input  1  single system clock, rising edge.
- `in_rst_n`  input  1  asynchronous, active-low reset.
- `in_stat`  input  6  current status word; sampled only at frame launch.
- `in_req`  input  1  one-cycle request to transmit the current `in_stat`.
- `out_tx`  output  1  UART TX line; idles high.
- `out_busy`  output  1  high from the launch cycle through the last stop-bit cycle.
- `out_done`  output  1  one-cycle pulse in the cycle after the stop bit ends.

## Operation
- States: IDLE, START, DATA, STOP.
- Trigger: `in_req`=1, or `AUTO_SEND`=1 and `in_stat` != `last_sent`.
- Launch, in IDLE with a trigger or `pending` set:
  - latch `shift = {2'b00, in_stat}` and `last_sent = in_stat`;
  - clear `pending`, go to START.
- START drives 0; DATA drives `shift[0]`, LSB first; STOP drives 1. Each bit lasts exactly `CLKS_PER_BIT` cycles.
- DATA shifts right once per bit. A 3-bit counter counts 0..7, and STOP follows bit 7.
- When the stop bit ends: go to IDLE and pulse `out_done`.
- Trigger while not IDLE:
  - set `pending` (one deep);
  - repeated triggers merge;
  - the frame it launches carries the `in_stat` value at its own launch, not at trigger time.
- AUTO_SEND: if the status changes during a frame, `pending` is set from the mismatch seen in IDLE after return. No extra storage is needed.
- After reset, `last_sent` is 0. A nonzero `in_stat` at reset release therefore triggers one frame when `AUTO_SEND`=1.
- Trigger and return to IDLE in the same cycle: the trigger is kept (sets `pending`) and launches in the next cycle.

## Timing
- Reset values: `out_tx`=1, `out_busy`=0, `out_done`=0; state IDLE; `pending`=0; `last_sent`=0; counters 0; `shift`=0.
- Reset mid-frame forces `out_tx` high immediately (asynchronously) and abandons the frame. Neither `out_done` nor a resend occurs unless `AUTO_SEND` detects a mismatch.
- `out_tx`, `out_busy` and `out_done` are registered outputs with no combinational path from inputs.
- Cycle T: `in_req` sampled in IDLE. T+1: `out_tx`=0 and `out_busy`=1.
- Frame length: 10·`CLKS_PER_BIT` cycles, running T+1 … T+10·`CLKS_PER_BIT`.
- Cycle T+10·`CLKS_PER_BIT`+1: `out_done`=1, `out_busy`=0, state IDLE.
- Back-to-back with `pending`: the next start bit begins at T+10·`CLKS_PER_BIT`+2. The minimum gap between frames is 1 cycle of idle-high.
- Baud counter width: `$clog2(CLKS_PER_BIT)`. It counts 0..`CLKS_PER_BIT`-1; the terminal count advances the bit. The counter is reset at launch.

## Structure
- Package `stat_tx_pkg`:
  - state enum `tx_state_t` (IDLE, START, DATA, STOP);
  - `FRAME_BITS`=10 and `DATA_BITS`=8;
  - `STAT_W`=6, shared with the status register.
- Sub-module `uart_baud_gen` (parameter `CLKS_PER_BIT`; ports `in_clk`, `in_rst_n`, `in_clr`, `out_tick`). It produces a one-cycle tick at the end of each bit period and is reused later by the RX side.
- The top holds the FSM, shift register, bit counter, `pending` and `last_sent`.

## Test plan
Bench uses `CLKS_PER_BIT`=4 unless stated.
- Reset, idle: with `AUTO_SEND`=0, `in_stat`=0, release reset and wait 100 cycles -> `out_tx`=1, `out_busy`=0, no `out_done`.
- Single request, `AUTO_SEND`=0:
  - stimulus: `in_stat`=6'h2D, `in_req` pulse at T;
  - line from T+1, 4 cycles per bit: 0,1,0,1,1,0,1,0,0,1 (byte 0x2D LSB first);
  - `out_done` at T+41.
- Back-to-back: `in_req` again at T+10 with `in_stat` changed to 6'h15 at T+20 -> second frame carries 0x15 and its start bit begins at T+42.
- Auto-send, `AUTO_SEND`=1:
  - change `in_stat` 0→6'h3F -> one frame 0x3F;
  - hold `in_stat` -> no further frames;
  - change to 6'h01 mid-frame -> exactly one more frame 0x01 after `out_done`.
- Reset mid-frame: assert `in_rst_n`=0 during bit 3 -> `out_tx`=1 in the same cycle and `out_busy`=0; after release with `AUTO_SEND`=0, no frame.
- `CLKS_PER_BIT`=2 corner: request plus a simultaneous request on the `out_done` cycle -> the second frame launches the next cycle, and the frame length is exactly 20 cycles.
